// File: rtl/iter_div_pkg.sv
// Shared types and message-field helpers for the iterative divider.
package iter_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } iter_div_state_e;

    // A message of width 2n holds two n-bit fields.
    // Field k occupies bits [k*n +: n].
    localparam int unsigned REQ_DIVIDEND_FIELD = 1;
    localparam int unsigned REQ_DIVISOR_FIELD  = 0;
    localparam int unsigned RESP_QUOT_FIELD    = 1;
    localparam int unsigned RESP_REM_FIELD     = 0;

endpackage

// File: rtl/iter_div_if.sv
// Request/response port bundle for the iterative divider.
// Handshake: a transfer happens on a rising edge where val and rdy are both 1.
// The sender holds val and msg stable until that transfer. The receiver may
// drive rdy freely, and rdy never depends combinationally on val.
interface iter_div_if #(parameter int p_nbits = 32);
    import iter_div_pkg::*;

    logic                 req_val;
    logic                 req_rdy;
    logic [2*p_nbits-1:0] req_msg;
    logic                 resp_val;
    logic                 resp_rdy;
    logic [2*p_nbits-1:0] resp_msg;

    modport master (output req_val, req_msg, resp_rdy,
                    input  req_rdy, resp_val, resp_msg);
    modport slave  (input  req_val, req_msg, resp_rdy,
                    output req_rdy, resp_val, resp_msg);
endinterface

// File: rtl/iter_div_ctrl.sv
// Control FSM of the iterative divider: IDLE -> CALC -> DONE -> IDLE.
// The bypass input lets a trivial operation jump straight from IDLE to DONE.
module iter_div_ctrl
    import iter_div_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_val,
    input  logic            resp_rdy,
    input  logic            cnt_done,
    input  logic            bypass,
    output logic            req_rdy,
    output logic            resp_val,
    output logic            load_en,
    output logic            step_en,
    output iter_div_state_e state
);
    iter_div_state_e state_n;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_val)  state_n = bypass ? DONE : CALC;
            CALC:    if (cnt_done) state_n = DONE;
            DONE:    if (resp_rdy) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        step_en  = 1'b0;
        case (state)
            IDLE:    req_rdy  = !reset;
            CALC:    step_en  = !reset;
            DONE:    resp_val = !reset;
            default: ;
        endcase
        load_en = req_val & req_rdy;
    end
endmodule

// File: rtl/vc_arith.sv
// Small combinational arithmetic building blocks used by the datapath.
module vc_Subtractor #(parameter int p_nbits = 32) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic [p_nbits-1:0] out
);
    assign out = in0 - in1;
endmodule

module vc_ZeroComparator #(parameter int p_nbits = 32) (
    input  logic [p_nbits-1:0] in,
    output logic               out
);
    assign out = (in == '0);
endmodule

module vc_Incrementer #(parameter int p_nbits = 32) (
    input  logic [p_nbits-1:0] in,
    output logic [p_nbits-1:0] out
);
    assign out = in + p_nbits'(1);
endmodule

// File: rtl/iter_div_unit.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Optional macro ITER_DIV_BYPASS_EN: zero divisor or zero dividend skips CALC.
module iter_div_unit
    import iter_div_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic            clk,
    input  logic            reset,
    iter_div_if.slave       io,
    output iter_div_state_e dbg_state
);
    localparam int CW = $clog2(p_nbits) + 1;

    // R never exceeds D-1 after a restoring step, so its top bit is always 0
    // once stored; only n bits are kept and the extra bit lives in r_shift.
    logic [p_nbits-1:0] r_reg, q_reg, d_reg;
    logic [p_nbits:0]   r_shift, diff;
    logic [p_nbits-1:0] q_shift, dividend, divisor, q_load, r_load;
    logic [CW-1:0]      cnt, cnt_inc;
    logic               cnt_done, bypass, load_en, step_en;

    assign dividend = io.req_msg[REQ_DIVIDEND_FIELD*p_nbits +: p_nbits];
    assign divisor  = io.req_msg[REQ_DIVISOR_FIELD*p_nbits  +: p_nbits];

    assign r_shift  = {r_reg, q_reg[p_nbits-1]};
    assign q_shift  = {q_reg[p_nbits-2:0], 1'b0};
    assign cnt_done = (cnt == CW'(p_nbits - 1));

    vc_Subtractor #(.p_nbits(p_nbits+1)) sub_u (
        .in0 (r_shift),
        .in1 ({1'b0, d_reg}),
        .out (diff)
    );

    vc_Incrementer #(.p_nbits(CW)) cnt_inc_u (
        .in  (cnt),
        .out (cnt_inc)
    );

`ifdef ITER_DIV_BYPASS_EN
    logic dvs_zero, dvd_zero;

    vc_ZeroComparator #(.p_nbits(p_nbits)) dvs_zc_u (.in(divisor),  .out(dvs_zero));
    vc_ZeroComparator #(.p_nbits(p_nbits)) dvd_zc_u (.in(dividend), .out(dvd_zero));

    // Load the final answer directly; divide-by-zero wins when both are zero.
    assign bypass = dvs_zero | dvd_zero;
    assign q_load = bypass ? (dvs_zero ? '1 : '0) : dividend;
    assign r_load = (bypass && dvs_zero) ? dividend : '0;
`else
    assign bypass = 1'b0;
    assign q_load = dividend;
    assign r_load = '0;
`endif

    iter_div_ctrl ctrl_u (
        .clk      (clk),
        .reset    (reset),
        .req_val  (io.req_val),
        .resp_rdy (io.resp_rdy),
        .cnt_done (cnt_done),
        .bypass   (bypass),
        .req_rdy  (io.req_rdy),
        .resp_val (io.resp_val),
        .load_en  (load_en),
        .step_en  (step_en),
        .state    (dbg_state)
    );

    // Datapath registers: load operands on accept, one shift/subtract per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg <= '0;
            q_reg <= '0;
            d_reg <= '0;
            cnt   <= '0;
        end else if (load_en) begin
            r_reg <= r_load;
            q_reg <= q_load;
            d_reg <= divisor;
            cnt   <= '0;
        end else if (step_en) begin
            cnt <= cnt_inc;
            if (!diff[p_nbits]) begin
                r_reg <= diff[p_nbits-1:0];
                q_reg <= {q_shift[p_nbits-1:1], 1'b1};
            end else begin
                r_reg <= r_shift[p_nbits-1:0];
                q_reg <= q_shift;
            end
        end
    end

    assign io.resp_msg[RESP_QUOT_FIELD*p_nbits +: p_nbits] = q_reg;
    assign io.resp_msg[RESP_REM_FIELD*p_nbits  +: p_nbits] = r_reg;
endmodule

// File: tb/tb_iter_div_unit.sv
// Bench for iter_div_unit: directed 8-bit checks and a random 32-bit stream.
module tb_iter_div_unit;
    import iter_div_pkg::*;

`ifdef ITER_DIV_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    localparam int LAT_FULL = 9;
    localparam int LAT_TRIV = BYP ? 1 : 9;
    localparam int N32      = 40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    iter_div_if #(.p_nbits(8))  if8 ();
    iter_div_if #(.p_nbits(32)) if32 ();
    iter_div_state_e st8, st32;

    iter_div_unit #(.p_nbits(8))  dut8  (.clk(clk), .reset(reset), .io(if8.slave),  .dbg_state(st8));
    iter_div_unit #(.p_nbits(32)) dut32 (.clk(clk), .reset(reset), .io(if32.slave), .dbg_state(st32));

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [63:0] exp32_q[$];
    int nvec = 0;
    int nerr = 0;

    function automatic logic [15:0] model8(logic [7:0] a, logic [7:0] b);
        if (b == 8'd0) return {8'hFF, a};
        return {a / b, a % b};
    endfunction

    function automatic logic [63:0] model32(logic [31:0] a, logic [31:0] b);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        return {a / b, a % b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // One 8-bit operation: latency check, optional backpressure, then handshake.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int lat, input int hold);
        int w;
        int l;
        logic [15:0] expv;
        logic [15:0] held;
        exp_q.push_back(model8(a, b));
        if8.resp_rdy = 1'b0;
        if8.req_msg  = {a, b};
        if8.req_val  = 1'b1;
        w = 0;
        while (!if8.req_rdy && w < 100) begin tick(); w++; end
        chk("req_accept_wait", 64'(w < 100), 64'd1);
        tick();
        if8.req_val = 1'b0;
        l = 1;
        while (!if8.resp_val && l < 100) begin tick(); l++; end
        chk("latency", 64'(l), 64'(lat));
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk("resp_msg", 64'(if8.resp_msg), 64'(expv));
        held = if8.resp_msg;
        for (int i = 0; i < hold; i++) begin
            if8.req_msg = {8'hAA, 8'h55};
            if8.req_val = 1'b1;
            tick();
            chk("hold_msg", 64'(if8.resp_msg), 64'(held));
            chk("hold_val", 64'(if8.resp_val), 64'd1);
            chk("hold_req_rdy", 64'(if8.req_rdy), 64'd0);
        end
        if8.req_val  = 1'b0;
        if8.resp_rdy = 1'b1;
        tick();
        if8.resp_rdy = 1'b0;
        chk("post_resp_val", 64'(if8.resp_val), 64'd0);
        chk("post_req_rdy", 64'(if8.req_rdy), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int got;
        int cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e32;

        if8.req_val  = 1'b0;
        if8.req_msg  = '0;
        if8.resp_rdy = 1'b0;
        if32.req_val  = 1'b0;
        if32.req_msg  = '0;
        if32.resp_rdy = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_req_rdy", 64'(if8.req_rdy), 64'd0);
        chk("rst_resp_val", 64'(if8.resp_val), 64'd0);
        chk("rst_state", 64'(st8), 64'(IDLE));
        reset = 1'b0;
        tick();
        chk("idle_req_rdy", 64'(if8.req_rdy), 64'd1);

        // directed operations
        op8(8'd100, 8'd7, LAT_FULL, 0);
        op8(8'd13,  8'd0, LAT_TRIV, 0);
        op8(8'd255, 8'd1, LAT_FULL, 0);
        op8(8'd7,   8'd9, LAT_FULL, 0);
        op8(8'd0,   8'd5, LAT_TRIV, 0);
        op8(8'd0,   8'd0, LAT_TRIV, 0);
        op8(8'd200, 8'd9, LAT_FULL, 5);
        op8(8'd128, 8'd128, LAT_FULL, 0);

        // reset in the middle of CALC abandons the operation
        if8.req_msg = {8'd50, 8'd3};
        if8.req_val = 1'b1;
        w = 0;
        while (!if8.req_rdy && w < 100) begin tick(); w++; end
        tick();
        if8.req_val = 1'b0;
        repeat (3) tick();
        chk("pre_rst_state", 64'(st8), 64'(CALC));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_state", 64'(st8), 64'(IDLE));
        if8.resp_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("mid_rst_no_resp", 64'(if8.resp_val), 64'd0);
            tick();
        end
        if8.resp_rdy = 1'b0;
        op8(8'd20, 8'd3, LAT_FULL, 0);

        // random 32-bit stream with stalls on both sides
        got = 0;
        fork
            begin
                for (int i = 0; i < N32; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    a = $urandom;
                    case ($urandom_range(0, 7))
                        0:       b = 32'd0;
                        1:       b = 32'($urandom_range(1, 15));
                        2:       begin a = 32'd0; b = $urandom; end
                        3:       b = a;
                        default: b = $urandom >> $urandom_range(0, 31);
                    endcase
                    if32.req_msg = {a, b};
                    if32.req_val = 1'b1;
                    w = 0;
                    while (!if32.req_rdy && w < 500) begin tick(); w++; end
                    chk("rand_accept_wait", 64'(w < 500), 64'd1);
                    exp32_q.push_back(model32(a, b));
                    tick();
                    if32.req_val = 1'b0;
                end
            end
            begin
                cyc = 0;
                while (got < N32 && cyc < 20000) begin
                    if32.resp_rdy = ($urandom_range(0, 3) != 0);
                    if (if32.resp_val && if32.resp_rdy) begin
                        e32 = (exp32_q.size() > 0) ? exp32_q.pop_front() : 64'hx;
                        chk("rand_resp", if32.resp_msg, e32);
                        got++;
                    end
                    tick();
                    cyc++;
                end
                if32.resp_rdy = 1'b0;
            end
        join
        chk("rand_count", 64'(got), 64'(N32));
        chk("rand_q_empty", 64'(exp32_q.size()), 64'd0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
